// File: rtl/grid_stat_pkg.sv
// Shared types and bin-word layout helpers for the grid statistics blocks.
// A bin word is {gray_sum, count, dist_sum}, with dist_sum in the LSBs.
package grid_stat_pkg;

  // Layout at the default widths (SUM_W=24, CNT_W=8, GRAY_W=16)
  localparam int SUM_LSB  = 0;
  localparam int SUM_MSB  = 23;
  localparam int CNT_LSB  = 24;
  localparam int CNT_MSB  = 31;
  localparam int GRAY_LSB = 32;
  localparam int GRAY_MSB = 47;

  typedef struct packed {
    logic [15:0] gray_sum;
    logic [7:0]  count;
    logic [23:0] dist_sum;
  } bin_word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_MERGE,
    ST_DIVIDE,
    ST_CORRECT,
    ST_EMIT,
    ST_CLEAR
  } state_t;

  function automatic int cnt_lsb(input int sum_w);
    return sum_w;
  endfunction

  function automatic int gray_lsb(input int sum_w, input int cnt_w);
    return sum_w + cnt_w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/grid_seq_divider.sv
// Restoring divider: one quotient bit per cycle, NUM_W cycles after start.
// done pulses for one cycle; quotient holds until the next start.
module grid_seq_divider
  import grid_stat_pkg::*;
#(
  parameter int NUM_W = 25,
  parameter int DEN_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  localparam int CB = $clog2(NUM_W + 1);

  logic [DEN_W-1:0] rem;
  logic [DEN_W-1:0] den_r;
  logic [CB-1:0]    cnt;
  logic [DEN_W:0]   trial;
  logic [DEN_W:0]   diff;
  logic             qbit;
  logic [DEN_W-1:0] rem_nxt;

  always_comb begin
    trial   = {rem, quotient[NUM_W-1]};
    diff    = trial - {1'b0, den_r};
    qbit    = (trial >= {1'b0, den_r});
    rem_nxt = qbit ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      den_r    <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quotient <= num;
        den_r    <= den;
        rem      <= '0;
        cnt      <= CB'(NUM_W);
        busy     <= 1'b1;
      end else if (busy) begin
        rem      <= rem_nxt;
        quotient <= {quotient[NUM_W-2:0], qbit};
        cnt      <= cnt - 1'b1;
        if (cnt == CB'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/grid_peak_estimator.sv
// Scans one histogram bank, merges the peak bin with its best neighbour,
// divides out average distance/gray, then clears the bank.
module grid_peak_estimator
  import grid_stat_pkg::*;
#(
  parameter int NUM_BINS    = 81,
  parameter int ADDR_W      = 8,
  parameter int CNT_W       = 8,
  parameter int SUM_W       = 24,
  parameter int GRAY_W      = 16,
  parameter int RD_LAT      = 2,
  parameter int NEIGH_SHIFT = 4,
  parameter int MIN_PEAK    = 20,
  parameter int CORR_OFFSET = 18,
  parameter int OUT_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          bank_sel,
  input  logic [CNT_W-1:0]              valid_num_threshold,
  input  logic [7:0]                    corr_pulse_width,
  output logic                          ram_bank,
  output logic                          ram_rden,
  output logic                          ram_wren,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [GRAY_W+CNT_W+SUM_W-1:0] ram_wrdata,
  input  logic [GRAY_W+CNT_W+SUM_W-1:0] ram_rddata,
  output logic                          busy,
  output logic                          overrun,
  output logic                          target_valid,
  output logic                          target_hit,
  output logic [OUT_W-1:0]              target_pos,
  output logic [OUT_W-1:0]              target_gray,
  output logic [CNT_W:0]                target_count
);

  localparam int WORD_W     = GRAY_W + CNT_W + SUM_W;
  localparam int P_CNT_LSB  = cnt_lsb(SUM_W);
  localparam int P_GRAY_LSB = gray_lsb(SUM_W, CNT_W);
  localparam int DIV_W      = max_int(SUM_W, GRAY_W) + 1;
  localparam int DEN_W      = CNT_W + 1;
  localparam int CB         = $clog2(NUM_BINS + RD_LAT + 1);
  localparam int CW         = GRAY_W + CNT_W + 16;
  localparam int XW         = DIV_W + OUT_W;
  localparam int OW1        = OUT_W + 1;
  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NUM_BINS - 1);

  state_t state, state_nxt;
  logic [CB-1:0] cnt;
  logic          bs_q, edge_r;

  logic [RD_LAT-1:0] vld_pipe;
  logic [ADDR_W-1:0] idx_pipe [RD_LAT];
  logic              rd_v;
  logic [ADDR_W-1:0] rd_i;
  logic [CNT_W-1:0]  rd_cnt;
  logic              upd;

  logic [WORD_W-1:0] prev_word, peak_word, before_word, after_word;
  logic              want_after;
  logic [ADDR_W-1:0] peak_bin;

  logic [CNT_W-1:0]  pk_cnt, bf_cnt, af_cnt, m_thr;
  logic [SUM_W-1:0]  pk_dist, bf_dist, af_dist;
  logic [GRAY_W-1:0] pk_gray, bf_gray, af_gray;
  logic              b_ok, a_ok, take_after, take_before, hit_c;
  logic [DEN_W-1:0]  den_c, m_den;
  logic [SUM_W:0]    dist_c;
  logic [GRAY_W:0]   gray_c, m_gray;

  logic             div_start, dist_busy, gray_busy, dist_done, gray_done;
  logic [DIV_W-1:0] dist_q, gray_q;

  logic [7:0]       lo_k;
  logic [8:0]       hi_k;
  logic [CW-1:0]    lo_p, hi_p, g10;
  logic             corr_ok;
  logic [OUT_W-1:0] pos_sat, gray_sat, pos_corr;
  logic [OW1-1:0]   pos_sum;

  function automatic logic [OUT_W-1:0] sat_q(input logic [DIV_W-1:0] q);
    logic [XW-1:0] wide, lim;
    wide = XW'(q);
    lim  = XW'({OUT_W{1'b1}});
    return (wide > lim) ? '1 : wide[OUT_W-1:0];
  endfunction

  assign ram_wrdata = '0;
  assign busy       = (state != ST_IDLE);

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ram_rden  = 1'b0;
    ram_wren  = 1'b0;
    unique case (state)
      ST_IDLE:    if (edge_r && enable) state_nxt = ST_SCAN;
      ST_SCAN: begin
        ram_rden = (cnt < CB'(NUM_BINS));
        if (cnt == CB'(NUM_BINS + RD_LAT - 1)) state_nxt = ST_MERGE;
      end
      ST_MERGE:   state_nxt = hit_c ? ST_DIVIDE : ST_EMIT;
      ST_DIVIDE:  if (dist_done && gray_done) state_nxt = ST_CORRECT;
      ST_CORRECT: state_nxt = ST_EMIT;
      ST_EMIT:    state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        ram_wren = 1'b1;
        if (cnt == CB'(NUM_BINS - 1)) state_nxt = ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Step counter, bank_sel edge detect, RAM address/bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      bs_q     <= 1'b0;
      edge_r   <= 1'b0;
      overrun  <= 1'b0;
      ram_bank <= 1'b0;
      ram_addr <= '0;
    end else begin
      bs_q    <= bank_sel;
      edge_r  <= bank_sel ^ bs_q;
      overrun <= edge_r && (state != ST_IDLE);
      cnt     <= (state_nxt != state) ? '0 : cnt + 1'b1;
      if (state == ST_IDLE && state_nxt == ST_SCAN) ram_bank <= bs_q;
      if ((state_nxt == ST_SCAN && state != ST_SCAN) ||
          (state_nxt == ST_CLEAR && state != ST_CLEAR))
        ram_addr <= '0;
      else if ((state == ST_SCAN || state == ST_CLEAR) && cnt < CB'(NUM_BINS - 1))
        ram_addr <= ram_addr + 1'b1;
    end
  end

  // Read-data tag pipeline matching the RAM latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) idx_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= ram_rden;
      idx_pipe[0] <= ram_addr;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  assign rd_v   = vld_pipe[RD_LAT-1];
  assign rd_i   = idx_pipe[RD_LAT-1];
  assign rd_cnt = ram_rddata[P_CNT_LSB +: CNT_W];
  assign upd    = rd_v && (rd_cnt > pk_cnt) &&
                  ((rd_i != LAST_BIN) || (pk_cnt < valid_num_threshold));

  // Sliding window: prev_word is bin i-1; the word following a peak becomes
  // after, unless that word itself becomes the new peak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_word   <= '0;
      peak_word   <= '0;
      before_word <= '0;
      after_word  <= '0;
      want_after  <= 1'b0;
      peak_bin    <= '0;
    end else if (state == ST_CLEAR && state_nxt == ST_IDLE) begin
      prev_word   <= '0;
      peak_word   <= '0;
      before_word <= '0;
      after_word  <= '0;
      want_after  <= 1'b0;
      peak_bin    <= '0;
    end else if (rd_v) begin
      prev_word <= ram_rddata;
      if (want_after) begin
        after_word <= ram_rddata;
        want_after <= 1'b0;
      end
      if (upd) begin
        peak_word   <= ram_rddata;
        peak_bin    <= rd_i;
        before_word <= prev_word;
        after_word  <= '0;
        want_after  <= (rd_i != LAST_BIN);
      end
    end
  end

  assign pk_cnt  = peak_word[P_CNT_LSB +: CNT_W];
  assign pk_dist = peak_word[0 +: SUM_W];
  assign pk_gray = peak_word[P_GRAY_LSB +: GRAY_W];
  assign bf_cnt  = before_word[P_CNT_LSB +: CNT_W];
  assign bf_dist = before_word[0 +: SUM_W];
  assign bf_gray = before_word[P_GRAY_LSB +: GRAY_W];
  assign af_cnt  = after_word[P_CNT_LSB +: CNT_W];
  assign af_dist = after_word[0 +: SUM_W];
  assign af_gray = after_word[P_GRAY_LSB +: GRAY_W];

  assign hit_c = (peak_bin != '0) && (pk_cnt >= CNT_W'(MIN_PEAK));

  always_comb begin
    m_thr       = pk_cnt >> NEIGH_SHIFT;
    b_ok        = (bf_cnt > m_thr);
    a_ok        = (af_cnt > m_thr);
    take_after  = a_ok && (!b_ok || af_cnt >= bf_cnt);
    take_before = b_ok && !take_after;
    den_c       = {1'b0, pk_cnt};
    dist_c      = {1'b0, pk_dist};
    gray_c      = {1'b0, pk_gray};
    if (take_after) begin
      den_c  = den_c + {1'b0, af_cnt};
      dist_c = dist_c + {1'b0, af_dist};
      gray_c = gray_c + {1'b0, af_gray};
    end else if (take_before) begin
      den_c  = den_c + {1'b0, bf_cnt};
      dist_c = dist_c + {1'b0, bf_dist};
      gray_c = gray_c + {1'b0, bf_gray};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_den  <= '0;
      m_gray <= '0;
    end else if (state == ST_MERGE) begin
      m_den  <= den_c;
      m_gray <= gray_c;
    end
  end

  assign div_start = (state == ST_MERGE) && hit_c && !dist_busy && !gray_busy;

  grid_seq_divider #(.NUM_W(DIV_W), .DEN_W(DEN_W)) u_div_dist (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .num      (DIV_W'(dist_c)),
    .den      (den_c),
    .busy     (dist_busy),
    .done     (dist_done),
    .quotient (dist_q)
  );

  grid_seq_divider #(.NUM_W(DIV_W), .DEN_W(DEN_W)) u_div_gray (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .num      (DIV_W'(gray_c)),
    .den      (den_c),
    .busy     (gray_busy),
    .done     (gray_done),
    .quotient (gray_q)
  );

  // Correction window compared in the x10 gray domain to avoid a divide
  assign lo_k    = (corr_pulse_width < 8'd3) ? 8'd0 : corr_pulse_width - 8'd3;
  assign hi_k    = {1'b0, corr_pulse_width} + 9'd3;
  assign lo_p    = CW'(lo_k) * CW'(m_den);
  assign hi_p    = CW'(hi_k) * CW'(m_den);
  assign g10     = CW'(m_gray) * CW'(10);
  assign corr_ok = (lo_p <= g10) && (g10 < hi_p);

  assign pos_sat  = sat_q(dist_q);
  assign gray_sat = sat_q(gray_q);
  assign pos_sum  = {1'b0, pos_sat} + OW1'(CORR_OFFSET);
  assign pos_corr = pos_sum[OUT_W] ? '1 : pos_sum[OUT_W-1:0];

  // Results are registered on entry to EMIT so they line up with target_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_valid <= 1'b0;
      target_hit   <= 1'b0;
      target_pos   <= '0;
      target_gray  <= '0;
      target_count <= '0;
    end else if (state == ST_MERGE && !hit_c) begin
      target_valid <= 1'b1;
      target_hit   <= 1'b0;
      target_pos   <= '0;
      target_gray  <= '0;
      target_count <= '0;
    end else if (state == ST_CORRECT) begin
      target_valid <= 1'b1;
      target_hit   <= 1'b1;
      target_pos   <= corr_ok ? pos_corr : pos_sat;
      target_gray  <= gray_sat;
      target_count <= m_den;
    end else begin
      target_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_grid_peak_estimator.sv
// Directed bench for grid_peak_estimator with a 2-cycle-latency ping-pong RAM model.
module tb_grid_peak_estimator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        bank_sel;
  logic [7:0]  valid_num_threshold;
  logic [7:0]  corr_pulse_width;
  logic        ram_bank, ram_rden, ram_wren;
  logic [7:0]  ram_addr;
  logic [47:0] ram_wrdata, ram_rddata;
  logic        busy, overrun, target_valid, target_hit;
  logic [15:0] target_pos, target_gray;
  logic [8:0]  target_count;

  always #5 clk = ~clk;

  grid_peak_estimator dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .enable              (enable),
    .bank_sel            (bank_sel),
    .valid_num_threshold (valid_num_threshold),
    .corr_pulse_width    (corr_pulse_width),
    .ram_bank            (ram_bank),
    .ram_rden            (ram_rden),
    .ram_wren            (ram_wren),
    .ram_addr            (ram_addr),
    .ram_wrdata          (ram_wrdata),
    .ram_rddata          (ram_rddata),
    .busy                (busy),
    .overrun             (overrun),
    .target_valid        (target_valid),
    .target_hit          (target_hit),
    .target_pos          (target_pos),
    .target_gray         (target_gray),
    .target_count        (target_count)
  );

  // RAM model: all writes go through this process
  logic [47:0] mem [2][81];
  logic [47:0] rd_s1;
  logic        ld_en = 1'b0, ld_clr = 1'b0, ld_bank = 1'b0;
  logic [7:0]  ld_addr = '0;
  logic [47:0] ld_data = '0;

  always @(posedge clk) begin
    if (ld_clr)
      for (int i = 0; i < 81; i++) begin
        mem[0][i] <= '0;
        mem[1][i] <= '0;
      end
    if (ld_en) mem[ld_bank][ld_addr] <= ld_data;
    if (ram_wren) mem[ram_bank][ram_addr] <= ram_wrdata;
    rd_s1      <= mem[ram_bank][ram_addr];
    ram_rddata <= rd_s1;
  end

  // Monitor
  int vld_cnt = 0, ovr_cyc = 0, both_cnt = 0, wr_bad = 0;
  int wr_run = 0, wr_last = 0, rd_run = 0, rd_last = 0;
  logic        cap_hit = 1'b0;
  logic [15:0] cap_pos = '0, cap_gray = '0;
  logic [8:0]  cap_cnt = '0;

  always @(negedge clk) begin
    if (target_valid) begin
      vld_cnt++;
      cap_hit  = target_hit;
      cap_pos  = target_pos;
      cap_gray = target_gray;
      cap_cnt  = target_count;
    end
    if (overrun) ovr_cyc++;
    if (ram_rden && ram_wren) both_cnt++;
    if (ram_wren) begin
      if (ram_addr != wr_run[7:0] || ram_wrdata != '0) wr_bad++;
      wr_run++;
    end else if (wr_run != 0) begin
      wr_last = wr_run;
      wr_run  = 0;
    end
    if (ram_rden) begin
      if (ram_addr != rd_run[7:0]) wr_bad++;
      rd_run++;
    end else if (rd_run != 0) begin
      rd_last = rd_run;
      rd_run  = 0;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Writes one bin into the bank the next bank_sel toggle will select
  task automatic load(input logic [7:0] bin, input logic [7:0] c,
                      input logic [23:0] d, input logic [15:0] g);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_bank = !bank_sel;
    ld_addr = bin;
    ld_data = {g, c, d};
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic frame(input string tag, input logic e_hit, input logic [8:0] e_cnt,
                       input logic [15:0] e_pos, input logic [15:0] e_gray);
    int v0, n;
    logic sb;
    logic [47:0] acc;
    v0 = vld_cnt;
    @(negedge clk);
    bank_sel = !bank_sel;
    sb = bank_sel;
    n = 0;
    while (vld_cnt == v0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    wait_idle();
    chk({tag, "_valid_pulses"}, 64'(vld_cnt - v0), 64'd1);
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    chk({tag, "_hit"}, 64'(cap_hit), 64'(e_hit));
    chk({tag, "_count"}, 64'(cap_cnt), 64'(e_cnt));
    chk({tag, "_pos"}, 64'(cap_pos), 64'(e_pos));
    chk({tag, "_gray"}, 64'(cap_gray), 64'(e_gray));
    chk({tag, "_pos_held"}, 64'(target_pos), 64'(e_pos));
    chk({tag, "_bank"}, 64'(ram_bank), 64'(sb));
    chk({tag, "_rden_run"}, 64'(rd_last), 64'd81);
    chk({tag, "_wren_run"}, 64'(wr_last), 64'd81);
    acc = '0;
    for (int i = 0; i < 81; i++) acc = acc | mem[sb][i];
    chk({tag, "_bank_cleared"}, 64'(acc), 64'd0);
  endtask

  initial begin
    int v0, o0, n;
    rst_n = 1'b0;
    enable = 1'b0;
    bank_sel = 1'b0;
    valid_num_threshold = 8'd255;
    corr_pulse_width = 8'd0;
    ld_clr = 1'b1;
    repeat (3) @(negedge clk);
    ld_clr = 1'b0;
    chk("reset_outputs",
        64'({busy, overrun, target_valid, target_hit, target_pos, target_gray,
             target_count, ram_rden, ram_wren, ram_addr, ram_bank}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Edges with enable low are ignored
    v0 = vld_cnt;
    bank_sel = 1'b1;
    repeat (6) @(negedge clk);
    chk("disabled_edge1_busy", 64'(busy), 64'd0);
    bank_sel = 1'b0;
    repeat (6) @(negedge clk);
    chk("disabled_edge2_busy", 64'(busy), 64'd0);
    chk("disabled_no_valid", 64'(vld_cnt - v0), 64'd0);
    enable = 1'b1;

    // Isolated peak, weak neighbours: 4000/40, 400/40
    load(8'd9, 8'd1, 24'd10, 16'd1);
    load(8'd10, 8'd40, 24'd4000, 16'd400);
    load(8'd11, 8'd1, 24'd10, 16'd1);
    frame("peak10", 1'b1, 9'd40, 16'd100, 16'd10);

    // Both neighbours qualify with equal counts: after wins, 3700/37
    load(8'd29, 8'd5, 24'd500, 16'd50);
    load(8'd30, 8'd32, 24'd3200, 16'd320);
    load(8'd31, 8'd5, 24'd500, 16'd50);
    frame("tie_after", 1'b1, 9'd37, 16'd100, 16'd10);

    // First maximum wins; last bin blocked by threshold 20
    valid_num_threshold = 8'd20;
    load(8'd5, 8'd25, 24'd2500, 16'd250);
    load(8'd60, 8'd25, 24'd2500, 16'd250);
    load(8'd80, 8'd30, 24'd6000, 16'd300);
    frame("last_blocked", 1'b1, 9'd25, 16'd100, 16'd10);

    // Threshold 30 lets the last bin take over (after=0): 6000/30
    valid_num_threshold = 8'd30;
    load(8'd5, 8'd25, 24'd2500, 16'd250);
    load(8'd60, 8'd25, 24'd2500, 16'd250);
    load(8'd80, 8'd30, 24'd6000, 16'd300);
    frame("last_taken", 1'b1, 9'd30, 16'd200, 16'd10);
    valid_num_threshold = 8'd255;

    // Peak at bin 0 is never a hit
    load(8'd0, 8'd100, 24'd9000, 16'd900);
    frame("bin0_nohit", 1'b0, 9'd0, 16'd0, 16'd0);

    // Avg gray 1.2 inside [7,13): 2000/40 + 18
    corr_pulse_width = 8'd10;
    load(8'd20, 8'd40, 24'd2000, 16'd48);
    frame("corr_on", 1'b1, 9'd40, 16'd68, 16'd1);

    corr_pulse_width = 8'd20;
    load(8'd20, 8'd40, 24'd2000, 16'd48);
    frame("corr_off", 1'b1, 9'd40, 16'd50, 16'd1);
    corr_pulse_width = 8'd0;

    // 2000000/20 saturates the position output
    load(8'd40, 8'd20, 24'd2000000, 16'd100);
    frame("pos_sat", 1'b1, 9'd20, 16'hFFFF, 16'd5);

    // Edge during SCAN: one overrun pulse, frame completes once
    load(8'd10, 8'd40, 24'd4000, 16'd400);
    v0 = vld_cnt;
    o0 = ovr_cyc;
    @(negedge clk);
    bank_sel = !bank_sel;
    repeat (12) @(negedge clk);
    chk("ovr_busy_in_scan", 64'(busy), 64'd1);
    bank_sel = !bank_sel;
    n = 0;
    while (vld_cnt == v0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    wait_idle();
    repeat (30) @(negedge clk);
    chk("ovr_pulse_cycles", 64'(ovr_cyc - o0), 64'd1);
    chk("ovr_one_frame", 64'(vld_cnt - v0), 64'd1);
    chk("ovr_idle_after", 64'(busy), 64'd0);
    chk("ovr_count", 64'(cap_cnt), 64'd40);
    chk("ovr_bank_kept", 64'(ram_bank), 64'd1);

    // Reset in the middle of DIVIDE
    load(8'd10, 8'd40, 24'd4000, 16'd400);
    v0 = vld_cnt;
    @(negedge clk);
    bank_sel = !bank_sel;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_frame_started", 64'(busy), 64'd1);
    repeat (89) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_outputs_zero",
        64'({busy, overrun, target_valid, target_hit, target_pos, target_gray,
             target_count, ram_rden, ram_wren, ram_addr, ram_bank}), 64'd0);
    bank_sel = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_no_emit", 64'(vld_cnt - v0), 64'd0);
    chk("rst_bank_not_cleared", 64'(mem[1][10]), 64'({16'd400, 8'd40, 24'd4000}));
    chk("rst_idle_after", 64'(busy), 64'd0);
    frame("after_reset", 1'b1, 9'd40, 16'd100, 16'd10);

    chk("rden_wren_exclusive", 64'(both_cnt), 64'd0);
    chk("strobe_addr_data", 64'(wr_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
